fetch_prefetch: RTL

In-order instruction prefetch unit at the front of the pipeline: owns the fetch PC, issues sequential instruction-memory requests, and buffers returned words with their PCs in a small FIFO for decode. It is the consumer of the execute stage's branch decision: a taken branch (`ex_valid && take_branch`) redirects the fetch PC to `branch_target`, flushes the buffer and discards responses still in flight.

---
 rtl/fetch_prefetch.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_prefetch.sv
// Sequential instruction prefetch: owns the fetch PC and buffers returned words with their PCs for decode.
// Latency: a response is visible to decode the cycle after it arrives; a redirect fetches the target the next cycle.
// Backpressure: requests are credit-limited so outstanding plus buffered words never exceed DEPTH.
module fetch_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        take_branch,
    input  logic [31:0] branch_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic          redirect;
    logic          req_fire;
    logic          pop;
    logic          push;
    logic          resp_live;
    logic          not_empty;
    logic [31:0]   target_pc;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] out_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [CW:0]   in_use;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    assign redirect  = ex_valid && take_branch;
    assign target_pc = branch_target & ~32'h3;
    assign in_use    = {1'b0, out_cnt} + {1'b0, count};
    assign not_empty = (count != '0);

    assign imem_req_valid = !redirect && (in_use < {1'b0, CNT_FULL});
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign if_valid = !redirect && not_empty;
    assign if_instr = not_empty ? instr_mem[rd_ptr] : 32'h0;
    assign if_pc    = not_empty ? pc_mem[rd_ptr]    : 32'h0;
    assign pop      = if_valid && if_ready;

    // Responses owed to a squashed fetch stream are consumed by drop_cnt, never pushed.
    assign resp_live = imem_resp_valid && !redirect;
    assign push      = resp_live && (drop_cnt == '0);

    always_comb begin
        out_nxt = out_cnt;
        if (req_fire && !imem_resp_valid) begin
            out_nxt = out_cnt + CNT_ONE;
        end else if (!req_fire && imem_resp_valid) begin
            out_nxt = out_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            out_cnt <= out_nxt;
            if (redirect) begin
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                drop_cnt <= out_nxt;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp_live && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_ONE;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (push && !pop) begin
                    count <= count + CNT_ONE;
                end else if (pop && !push) begin
                    count <= count - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= resp_pc;
            instr_mem[wr_ptr] <= imem_resp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (count == CNT_FULL)));
            assert (!(pop && !not_empty));
        end
    end
endmodule
